// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec_stage
//  Description : Execute-stage sequencer in front of a combinational ALU.
//                It accepts one decoded op, presents the ALU operands for one
//                cycle, captures the result and flags, and holds them until
//                writeback takes them. Three-state FSM: IDLE, EXEC, DONE.
//                Optional feature macro: ALU_EXEC_OVF_EN enables signed
//                overflow capture on out_ovf (add/sub/addi). Without it,
//                out_ovf is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_stage #(
    parameter int IMM_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [15:0]       reg_a,
    input  logic [15:0]       reg_b,
    input  logic [IMM_W-1:0]  imm,
    output logic [15:0]       alu_in1,
    output logic [15:0]       alu_in2,
    output logic [2:0]        alu_control,
    input  logic [15:0]       alu_result,
    input  logic              alu_zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_result,
    output logic              out_zero,
    output logic              out_branch,
    output logic              out_illegal,
    output logic              out_ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [15:0] reg_a_q, reg_a_d;
    logic [15:0] alu_in2_q, alu_in2_d;
    logic [2:0]  alu_ctl_q, alu_ctl_d;
    logic [15:0] out_result_q, out_result_d;
    logic        out_zero_q, out_zero_d;
    logic        out_branch_q, out_branch_d;
    logic        out_illegal_q, out_illegal_d;

    logic [15:0] imm_sext;
    logic [15:0] imm_zext;
    logic [15:0] dec_in2;
    logic [2:0]  dec_ctl;

    assign imm_sext = {{(16-IMM_W){imm[IMM_W-1]}}, imm};
    assign imm_zext = {{(16-IMM_W){1'b0}}, imm};

    // Decode the incoming op into ALU control and second operand at issue time,
    // so the ALU sees registered, glitch-free operands for the whole EXEC cycle.
    always_comb begin
        dec_ctl = 3'd0;
        dec_in2 = 16'd0;
        case (op)
            4'd0, 4'd1, 4'd2, 4'd3,
            4'd4, 4'd5, 4'd6, 4'd7: begin
                dec_ctl = op[2:0];
                dec_in2 = reg_b;
            end
            4'd8: begin
                dec_ctl = 3'd2;
                dec_in2 = imm_sext;
            end
            4'd9: begin
                dec_ctl = 3'd0;
                dec_in2 = imm_zext;
            end
            4'd10: begin
                dec_ctl = 3'd1;
                dec_in2 = imm_zext;
            end
            4'd11: begin
                dec_ctl = 3'd4;
                dec_in2 = {12'd0, imm[3:0]};
            end
            4'd12, 4'd13: begin
                dec_ctl = 3'd3;
                dec_in2 = reg_b;
            end
            default: begin
                // Illegal ops park the ALU on AND with a zero operand.
                dec_ctl = 3'd0;
                dec_in2 = 16'd0;
            end
        endcase
    end

`ifdef ALU_EXEC_OVF_EN
    logic out_ovf_q, out_ovf_d;
    logic ovf_calc;

    // Signed overflow: add overflows when like-signed operands give an
    // opposite-signed sum; sub overflows when unlike-signed operands give a
    // result whose sign differs from the minuend.
    always_comb begin
        ovf_calc = 1'b0;
        case (op_q)
            4'd2, 4'd8: ovf_calc = (reg_a_q[15] == alu_in2_q[15]) &&
                                   (alu_result[15] != reg_a_q[15]);
            4'd3:       ovf_calc = (reg_a_q[15] != alu_in2_q[15]) &&
                                   (alu_result[15] != reg_a_q[15]);
            default:    ovf_calc = 1'b0;
        endcase
    end
`endif

    // Next-state and capture logic; every register holds unless its state acts.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        reg_a_d       = reg_a_q;
        alu_in2_d     = alu_in2_q;
        alu_ctl_d     = alu_ctl_q;
        out_result_d  = out_result_q;
        out_zero_d    = out_zero_q;
        out_branch_d  = out_branch_q;
        out_illegal_d = out_illegal_q;
`ifdef ALU_EXEC_OVF_EN
        out_ovf_d     = out_ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d      = op;
                    reg_a_d   = reg_a;
                    alu_in2_d = dec_in2;
                    alu_ctl_d = dec_ctl;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                out_result_d  = (op_q < 4'd12) ? alu_result : 16'd0;
                out_zero_d    = alu_zero;
                out_branch_d  = (op_q == 4'd12) ? alu_zero :
                                (op_q == 4'd13) ? ~alu_zero : 1'b0;
                out_illegal_d = (op_q[3:1] == 3'b111);
`ifdef ALU_EXEC_OVF_EN
                out_ovf_d     = ovf_calc;
`endif
                state_d       = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight op.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            op_q          <= 4'd0;
            reg_a_q       <= 16'd0;
            alu_in2_q     <= 16'd0;
            alu_ctl_q     <= 3'd0;
            out_result_q  <= 16'd0;
            out_zero_q    <= 1'b0;
            out_branch_q  <= 1'b0;
            out_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            reg_a_q       <= reg_a_d;
            alu_in2_q     <= alu_in2_d;
            alu_ctl_q     <= alu_ctl_d;
            out_result_q  <= out_result_d;
            out_zero_q    <= out_zero_d;
            out_branch_q  <= out_branch_d;
            out_illegal_q <= out_illegal_d;
        end
    end

`ifdef ALU_EXEC_OVF_EN
    // Overflow flag register, present only when the feature is built in.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_ovf_q <= 1'b0;
        end else begin
            out_ovf_q <= out_ovf_d;
        end
    end

    assign out_ovf = out_ovf_q;
`else
    assign out_ovf = 1'b0;
`endif

    // Handshakes decode straight from the state register. out_valid rises
    // after the edge following accept, so writeback samples it two edges on.
    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);

    assign alu_in1     = reg_a_q;
    assign alu_in2     = alu_in2_q;
    assign alu_control = alu_ctl_q;

    assign out_result  = out_result_q;
    assign out_zero    = out_zero_q;
    assign out_branch  = out_branch_q;
    assign out_illegal = out_illegal_q;

endmodule
`default_nettype wire

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 Parameter: IMM_W, 8, immediate field width (4..15).
REQ-002 clock  input  1  rising-edge clock.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid / in_ready  input / output  1 / 1  issue handshake from decode.
REQ-005 op  input  4  operation code (map in REQ-012).
REQ-006 reg_a, reg_b  input  16 each  register-file operands.
REQ-007 imm  input  IMM_W  immediate field.
REQ-008 alu_in1, alu_in2, alu_control  output  16, 16, 3  drive the combinational ALU.
REQ-009 alu_result, alu_zero  input  16, 1  ALU result and isZero (in1-in2==0) return.
REQ-010 out_valid / out_ready  output / input  1 / 1  result handshake to writeback.
REQ-011 out_result 16, out_zero 1, out_branch 1, out_illegal 1, out_ovf 1  output  registered results and flags.

Function
REQ-012 Op map SHALL be: 0-7 reg-reg, control=op[2:0] (and,or,add,sub,sl,srl,sra,slt), in2=reg_b; 8 addi (ctl 2, in2=sign-ext imm); 9 andi (ctl 0, zero-ext imm); 10 ori (ctl 1, zero-ext imm); 11 slli (ctl 4, in2=zero-ext imm[3:0]); 12 beq (ctl 3, in2=reg_b); 13 bne (ctl 3, in2=reg_b); 14-15 illegal.
REQ-013 alu_in1 SHALL always be latched reg_a.
REQ-014 FSM states SHALL be IDLE, EXEC, DONE; reset state IDLE.
REQ-015 IDLE: in_ready=1; on in_valid=1 at an edge, op/reg_a/reg_b/imm latch and FSM -> EXEC.
REQ-016 EXEC: in_ready=0; alu_in1/alu_in2/alu_control driven from latched fields; at end of cycle out_* capture and FSM -> DONE.
REQ-017 DONE: out_valid=1, in_ready=0; out_* held stable; on out_ready=1 at an edge FSM -> IDLE and out_valid drops next cycle.
REQ-018 Latency: accept at edge N, out_valid=1 from edge N+2; max throughput one op per 3 cycles with out_ready tied 1.
REQ-019 out_result SHALL be alu_result for ops 0-11, 0 for ops 12-15.
REQ-020 out_zero SHALL be alu_zero captured in EXEC.
REQ-021 out_branch SHALL be alu_zero for op 12, ~alu_zero for op 13, 0 otherwise.
REQ-022 Illegal ops 14-15: out_illegal=1, alu_control=0, alu_in2=0, out_result=0, out_branch=0; handshake completes normally.
REQ-023 Sign extension SHALL replicate imm[IMM_W-1] to 16 bits; arithmetic wraps modulo 2^16.
REQ-024 in_valid in EXEC or DONE SHALL be ignored (no latch); upstream holds it until in_ready.
REQ-025 out_ready asserted while not in DONE SHALL have no effect.
REQ-026 alu_in1/alu_in2/alu_control SHALL hold last-driven values in IDLE and DONE (no glitching to ALU).

Reset
REQ-027 reset_n=0 SHALL immediately force IDLE, in_ready=1 after release, out_valid=0, out_result=0, out_zero/out_branch/out_illegal/out_ovf=0, alu_in1/alu_in2=0, alu_control=0, latches=0.
REQ-028 Reset during EXEC or DONE SHALL discard the in-flight op; no out_valid pulse follows release.

Configuration
REQ-029 Macro ALU_EXEC_OVF_EN: when defined, out_ovf SHALL capture signed overflow for ops 2, 3, 8 (add: operands same sign, result sign differs; sub: operands differ in sign, result sign differs from in1), 0 for all other ops.
REQ-030 Without ALU_EXEC_OVF_EN, out_ovf SHALL be constant 0 and no overflow logic synthesized; port list unchanged.

Verification (bench models the ALU combinationally)
REQ-031 op=2, reg_a=0x0005, reg_b=0x0003, out_ready=1 -> alu_control=2 in EXEC; out_valid two edges after accept; out_result=0x0008, out_zero=0.
REQ-032 op=8, reg_a=0x0010, imm=0xFF -> alu_in2=0xFFFF, out_result=0x000F; op=9, imm=0xFF, reg_a=0x1234 -> alu_in2=0x00FF, out_result=0x0034.
REQ-033 op=12, reg_a=reg_b=0x00AA -> out_branch=1, out_zero=1, out_result=0; op=13 same operands -> out_branch=0.
REQ-034 out_ready=0 for 5 cycles in DONE -> out_valid and out_result stable, in_ready=0, second in_valid ignored; out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-035 reset_n pulsed low mid-EXEC -> out_valid=0 and all outputs 0 immediately; no completion after release; op=15 afterwards -> out_illegal=1, out_result=0.
REQ-036 With ALU_EXEC_OVF_EN: op=2, reg_a=0x7FFF, reg_b=0x0001 -> out_result=0x8000, out_ovf=1; op=3, 0x8000-0x0001 -> out_ovf=1; without macro -> out_ovf=0 for both.
